pc_gen: RTL

Parametrised instruction-fetch program counter for the IF stage. Generates the fetch address and instruction-memory chip enable, and applies redirects in a fixed priority: exception/flush, buffered jump, live jump, sequential. Jumps arriving while IF is stalled are held in a one-entry buffer rather than lost. Sits at the head of the pipeline, feeding the instruction memory and the IF/ID register.

---
 rtl/project_types.sv | 21 ++
 rtl/pc_gen_if.sv | 27 ++
 rtl/pc_redirect_buf.sv | 28 ++
 rtl/pc_gen.sv | 125 ++++++++++++
 4 files changed

// File: rtl/project_types.sv
// project_types: types and defaults shared by the IF-stage PC generator.
//   pc_t        widest supported PC (ADDR_W <= PC_MAX_W); narrower instances
//               use the low ADDR_W bits and keep the upper bits zero.
//   redirect_t  {en, addr}: a jump request or the pending-jump buffer entry.
//   pc_state_t  PC_OFF (fetch disabled) / PC_RUN (fetching).
package project_types;

   localparam int          PC_MAX_W         = 32;
   localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
   localparam int          DEF_INSN_BYTES   = 4;

   typedef logic [PC_MAX_W-1:0] pc_t;

   typedef struct packed {
      logic en;
      pc_t  addr;
   } redirect_t;

   typedef enum logic {PC_OFF, PC_RUN} pc_state_t;

endpackage

// File: rtl/pc_gen_if.sv
// pc_gen_if: fetch-control bundle between the pipeline control and pc_gen.
//   master: pipeline side, drives stall/flush/jump requests, reads fetch outputs.
//   slave : pc_gen side.
//   stall[0] is the IF stall; the remaining stall bits are carried but unused here.
interface pc_gen_if #(
   parameter int ADDR_W  = 32,
   parameter int STALL_W = 6
);
   logic [STALL_W-1:0] stall;
   logic               flush;
   logic [ADDR_W-1:0]  flush_pc;
   logic               jump_en;
   logic [ADDR_W-1:0]  jump_addr;
   logic [ADDR_W-1:0]  if_pc_o;
   logic               if_ce_o;
   logic               if_misalign_o;

   modport master (
      output stall, flush, flush_pc, jump_en, jump_addr,
      input  if_pc_o, if_ce_o, if_misalign_o
   );

   modport slave (
      input  stall, flush, flush_pc, jump_en, jump_addr,
      output if_pc_o, if_ce_o, if_misalign_o
   );
endinterface

// File: rtl/pc_redirect_buf.sv
// pc_redirect_buf: one-entry holding register for a jump that arrives while
// IF is stalled.
//   clk, rst   clock, synchronous active-high reset (empties the entry)
//   set        load wr into an empty entry
//   overwrite  replace a valid entry with wr (latest jump wins)
//   clear      empty the entry (consumed or flushed); wins over set/overwrite
//   wr         jump request to capture ({1, target})
//   pend       current entry
module pc_redirect_buf
   import project_types::*;
(
   input  logic      clk,
   input  logic      rst,
   input  logic      set,
   input  logic      overwrite,
   input  logic      clear,
   input  redirect_t wr,
   output redirect_t pend
);

   always_ff @(posedge clk) begin
      if (rst || clear)
         pend <= '0;
      else if (set || overwrite)
         pend <= wr;
   end

endmodule

// File: rtl/pc_gen.sv
// pc_gen: instruction-fetch program counter.
//   clk, rst  clock, synchronous active-high reset
//   bus       pc_gen_if.slave: stall vector, flush + flush_pc, jump_en +
//             jump_addr in; if_pc_o, if_ce_o, if_misalign_o out (all registered)
// Redirect priority in RUN: flush > stalled jump capture > stall hold >
// buffered jump > live jump > sequential (+INSN_BYTES, wrapping).
// Optional: define PC_ALIGN_CHECK_EN to register |pc[1:0] on if_misalign_o;
// otherwise the output is tied low.
module pc_gen
   import project_types::*;
#(
   parameter int          ADDR_W       = 32,
   parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
   parameter int          INSN_BYTES   = DEF_INSN_BYTES,
   parameter int          STALL_W      = 6
) (
   input logic     clk,
   input logic     rst,
   pc_gen_if.slave bus
);

   localparam logic [ADDR_W-1:0] RV  = RESET_VECTOR[ADDR_W-1:0];
   localparam logic [ADDR_W-1:0] INC = ADDR_W'(INSN_BYTES);

   pc_state_t         state_q, state_nxt;
   logic [ADDR_W-1:0] pc_q, pc_nxt;
   redirect_t         pend, jump_req;
   logic              buf_set, buf_ovr, buf_clr;
   logic              stall_if;
   logic [ADDR_W-1:0] pend_addr;

   assign stall_if  = bus.stall[0];
   assign pend_addr = pend.addr[ADDR_W-1:0];

   // Jump target widened into the shared redirect record.
   always_comb begin
      jump_req                   = '0;
      jump_req.en                = bus.jump_en;
      jump_req.addr[ADDR_W-1:0]  = bus.jump_addr;
   end

   generate
      if (ADDR_W < PC_MAX_W) begin : g_pend_hi
         logic unused_pend_hi;
         assign unused_pend_hi = ^pend.addr[PC_MAX_W-1:ADDR_W];
      end
      if (STALL_W > 1) begin : g_stall_hi
         logic unused_stall_hi;
         assign unused_stall_hi = ^bus.stall[STALL_W-1:1];
      end
   endgenerate

   pc_redirect_buf u_buf (
      .clk       (clk),
      .rst       (rst),
      .set       (buf_set),
      .overwrite (buf_ovr),
      .clear     (buf_clr),
      .wr        (jump_req),
      .pend      (pend)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= PC_OFF;
         pc_q    <= RV;
      end else begin
         state_q <= state_nxt;
         pc_q    <= pc_nxt;
      end
   end

   always_comb begin
      state_nxt = state_q;
      pc_nxt    = pc_q;
      buf_set   = 1'b0;
      buf_ovr   = 1'b0;
      buf_clr   = 1'b0;
      unique case (state_q)
         PC_OFF: begin
            // First RUN cycle fetches RESET_VECTOR itself; increment follows.
            state_nxt = PC_RUN;
            pc_nxt    = RV;
            buf_clr   = 1'b1;
         end
         PC_RUN: begin
            if (bus.flush) begin
               pc_nxt  = bus.flush_pc;
               buf_clr = 1'b1;
            end else if (stall_if) begin
               if (bus.jump_en) begin
                  buf_set = !pend.en;
                  buf_ovr = pend.en;
               end
            end else if (pend.en) begin
               // Held jump is older than any live one, so it goes first.
               pc_nxt  = pend_addr;
               buf_clr = 1'b1;
            end else if (bus.jump_en) begin
               pc_nxt = bus.jump_addr;
            end else begin
               pc_nxt = pc_q + INC;
            end
         end
         default: state_nxt = PC_OFF;
      endcase
   end

   assign bus.if_pc_o = pc_q;
   assign bus.if_ce_o = (state_q == PC_RUN);

`ifdef PC_ALIGN_CHECK_EN
   logic mis_q;
   always_ff @(posedge clk) begin
      if (rst)
         mis_q <= 1'b0;
      else
         mis_q <= |pc_nxt[1:0];
   end
   assign bus.if_misalign_o = mis_q;
`else
   assign bus.if_misalign_o = 1'b0;
`endif

endmodule
